// File: rtl/aes128_inv_cipher_iter_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher: round count,
// FSM encoding, inverse S-box, xtime and the byte-packing helper.
package aes128_inv_cipher_iter_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_ROUND = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_e;

  // Entry 0 sits in the top byte so the table reads in the usual row order.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k = row + 4*col lives at bits [127-8k -: 8]; this returns the LSB.
  function automatic int byte_lsb(input int row, input int col);
    return 120 - 8 * (row + 4 * col);
  endfunction

endpackage

// File: rtl/aes128_inv_cipher_iter_inv_shift_rows.sv
// Combinational InvShiftRows: row r of the state rotates right by r columns.
module inv_shift_rows
  import aes128_inv_cipher_iter_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[byte_lsb(r, c) +: 8] = state_i[byte_lsb(r, (c - r + 4) % 4) +: 8];
    end
  end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one block decrypted over ten clocked
// rounds, round keys fetched by index from an external store.
module aes128_inv_cipher_iter
  import aes128_inv_cipher_iter_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;

  logic [127:0] isr_w;
  logic [127:0] isb_w;
  logic [127:0] t_w;
  logic [127:0] imc_w;

  inv_shift_rows u_inv_shift_rows (
    .state_i (state_q),
    .state_o (isr_w)
  );

  for (genvar k = 0; k < 16; k++) begin : g_isb
    assign isb_w[byte_lsb(k % 4, k / 4) +: 8] = inv_sbox(isr_w[byte_lsb(k % 4, k / 4) +: 8]);
  end

  assign t_w = isb_w ^ rk_data;

  // Multiples 9, b, d, e of every byte are built from a chain of three xtimes.
  for (genvar c = 0; c < 4; c++) begin : g_imc
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    for (genvar r = 0; r < 4; r++) begin : g_mul
      logic [7:0] a, x2, x4, x8;
      assign a     = t_w[byte_lsb(r, c) +: 8];
      assign x2    = xtime(a);
      assign x4    = xtime(x2);
      assign x8    = xtime(x4);
      assign m9[r] = x8 ^ a;
      assign mb[r] = x8 ^ x2 ^ a;
      assign md[r] = x8 ^ x4 ^ a;
      assign me[r] = x8 ^ x4 ^ x2;
    end

    for (genvar r = 0; r < 4; r++) begin : g_out
      assign imc_w[byte_lsb(r, c) +: 8] =
        me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= FSM_IDLE;
      rnd_q   <= 4'd0;
      state_q <= 128'd0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  // The final round (rnd 0) skips InvMixColumns and parks the result in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    case (fsm_q)
      FSM_IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ rk_data;
          rnd_d   = 4'(NR - 1);
          fsm_d   = FSM_ROUND;
        end
      end
      FSM_ROUND: begin
        if (rnd_q != 4'd0) begin
          state_d = imc_w;
          rnd_d   = rnd_q - 4'd1;
        end else begin
          state_d = t_w;
          fsm_d   = FSM_DONE;
        end
      end
      FSM_DONE: begin
        if (out_ready) begin
          fsm_d = FSM_IDLE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  // Key index follows the FSM and round counter only, never in_valid.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 128'd0;
    rk_idx    = 4'(NR);
    case (fsm_q)
      FSM_IDLE:  in_ready = 1'b1;
      FSM_ROUND: rk_idx = rnd_q;
      FSM_DONE: begin
        out_valid = 1'b1;
        out_data  = state_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/aes128_inv_cipher_iter.md
Name: aes128_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher); decrypts one 128-bit block in 10 clocked rounds.
- Pairs with the forward AES-128 datapath and its ShiftRows stage; shares the same byte/bit packing.
- Round keys are not expanded here. They are read by index from the external key-expansion/round-key store.
- Valid/ready on input and output.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext valid
- in_ready  out  1  block can accept a ciphertext
- in_data  in  128  ciphertext; byte k at bits [127-8k -: 8]; byte k = row (k mod 4), column (k div 4)
- rk_idx  out  4  round-key index requested (0..10)
- rk_data  in  128  round key for rk_idx, combinational, same packing
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same packing

Behaviour:
- Reset (async, rst_n=0): fsm=IDLE, rnd=0, state=0, in_ready=1, out_valid=0, out_data=0, rk_idx=10.
- Reset mid-operation aborts the block; no output is produced for it.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=10.
  - On in_valid&&in_ready: state<=in_data^rk_data, rnd<=9, go to ROUND.
- ROUND:
  - in_ready=0, rk_idx=rnd.
  - Each edge: t = InvSubBytes(InvShiftRows(state)) ^ rk_data.
  - If rnd!=0: state<=InvMixColumns(t), rnd<=rnd-1.
  - If rnd==0: state<=t, go to DONE. Final round has no InvMixColumns.
- DONE:
  - out_valid=1, out_data=state, held stable until out_ready.
  - On out_ready: go to IDLE, out_valid<=0.
  - in_ready stays 0 in DONE; no same-cycle bypass.
- Latency: acceptance edge E0, rounds on E1..E10, out_valid=1 after E10. One block per at least 12 cycles.
- out_valid backpressure is unbounded; state is held and no input is accepted.
- in_data is sampled only on the acceptance edge; changes afterwards are ignored.
- rk_data must be valid in the same cycle rk_idx is driven; the store is combinational or registered one index ahead.
- rk_idx is a registered/decoded function of fsm and rnd only; it never depends on in_valid.
- InvShiftRows: row r rotates right by r, out[r+4c] = in[r+4((c-r) mod 4)].
- InvSubBytes: inverse S-box per byte.
- InvMixColumns, per column a0..a3:
  - matrix rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}
  - arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1, built from chained xtime.
- in_valid while busy is ignored; it is neither latched nor dropped silently. It waits for in_ready.

Decomposition:
- Shared package/include holds:
  - inverse S-box table as a function inv_sbox(byte)
  - xtime function and AES_NR=10
  - FSM state encodings
  - byte-index helper (row, col)->bit slice; must match the forward datapath.
- One sub-module, inv_shift_rows: combinational, 128 in/128 out.
- InvSubBytes/InvMixColumns are inline generate loops using the package functions.

Test Plan:
- inv_shift_rows alone: in 000102030405060708090a0b0c0d0e0f -> out 000d0a0704010e0b0805020f0c09060 3 (bytes 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03).
- FIPS-197 C.1, key 000102..0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5):
  - ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff
  - out_valid rises exactly 10 edges after acceptance
  - rk_idx sequence observed: 10,9,...,0.
- FIPS-197 Appendix B, key 2b7e151628aed2a6abf7158809cf4f3c: ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 and a new ct -> out_data stable, in_ready=0 throughout, second block accepted only after the first handshake.
- Reset mid-round: assert rst_n=0 at round 5 -> outputs immediately at reset values. A following C.1 vector decrypts correctly.
- Back-to-back: two vectors with out_ready tied 1 -> both correct, acceptance edges 12 cycles apart.
